binary_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-add-3 (double-dabble) method, one input bit per clock. Generalises the team's fixed 4-bit combinational converter to any input width and digit count, with optional two's-complement input and valid/ready handshakes on both sides. Sits between arithmetic datapaths and display/UART formatting blocks, where a multi-cycle latency is acceptable in exchange for small area.

---
 rtl/binary_to_bcd_seq.sv | 138 +++++++++++++
 tb/tb_binary_to_bcd_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock,
// with optional two's-complement input and valid/ready handshakes on both sides.
module binary_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out
);

  localparam int  BCD_W     = 4 * DIGITS;
  localparam int  WORK_W    = BCD_W + BIN_W;
  localparam int  CNT_W     = $clog2(BIN_W + 1);
  localparam bit  IS_SIGNED = (SIGNED != 0);

  // The largest unsigned input (2^BIN_W - 1) must fit in DIGITS decimal digits.
  function automatic bit digits_fit();
    logic [127:0] pow10;
    pow10 = 128'd1;
    for (int i = 0; i < DIGITS; i++) begin
      pow10 = pow10 * 128'd10;
    end
    return pow10 > ((128'd1 << BIN_W) - 128'd1);
  endfunction

  localparam bit DIGITS_OK = digits_fit();

  if (BIN_W < 2) begin : g_bin_w_check
    $error("binary_to_bcd_seq: BIN_W must be at least 2");
  end
  if (!DIGITS_OK) begin : g_digits_check
    $error("binary_to_bcd_seq: DIGITS too small to hold 2^BIN_W - 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                sign_q, sign_d;
  logic                neg_q, neg_d;
  logic [WORK_W-1:0]   adj_s;
  logic [BIN_W-1:0]    mag_s;
  logic                in_neg_s;

  assign in_neg_s = IS_SIGNED & in_data[BIN_W-1];
  assign mag_s    = in_neg_s ? (~in_data + BIN_W'(1)) : in_data;

  // Next-state, datapath and result-register update
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    neg_d   = neg_q;
    adj_s   = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = {{BCD_W{1'b0}}, mag_s};
          neg_d   = in_neg_s;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Correct every digit before the shift so it carries into the next decade.
        for (int d = 0; d < DIGITS; d++) begin
          if (work_q[BIN_W + 4*d +: 4] >= 4'd5) begin
            adj_s[BIN_W + 4*d +: 4] = work_q[BIN_W + 4*d +: 4] + 4'd3;
          end else begin
            adj_s[BIN_W + 4*d +: 4] = work_q[BIN_W + 4*d +: 4];
          end
        end
        work_d = {adj_s[WORK_W-2:0], 1'b0};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = work_d[WORK_W-1 -: BCD_W];
          sign_d  = neg_q;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, working register and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= {WORK_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      bcd_q   <= {BCD_W{1'b0}};
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_q;
  assign sign_out  = sign_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Randomised self-checking bench for binary_to_bcd_seq: unsigned 8-bit,
// signed 8-bit and unsigned 16-bit instances against a decimal reference model.
module tb_binary_to_bcd_seq;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic        iv    [3];
  logic [15:0] idata [3];
  logic        ordy  [3];
  logic        ov_a  [3];
  logic        ir_a  [3];
  logic        sg_a  [3];
  logic [19:0] bcd_a [3];

  int bw [3] = '{8, 8, 16};
  int sgn[3] = '{0, 1, 0};

  logic [11:0] bcd0, bcd1;
  logic [19:0] bcd2;
  logic ov0, ov1, ov2, ir0, ir1, ir2, s0, s1, s2;

  binary_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_uns8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .in_data(idata[0][7:0]),
    .out_valid(ov0), .out_ready(ordy[0]), .bcd_out(bcd0), .sign_out(s0));
  binary_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_sgn8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .in_data(idata[1][7:0]),
    .out_valid(ov1), .out_ready(ordy[1]), .bcd_out(bcd1), .sign_out(s1));
  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_uns16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .in_data(idata[2]),
    .out_valid(ov2), .out_ready(ordy[2]), .bcd_out(bcd2), .sign_out(s2));

  assign ov_a[0] = ov0;  assign ov_a[1] = ov1;  assign ov_a[2] = ov2;
  assign ir_a[0] = ir0;  assign ir_a[1] = ir1;  assign ir_a[2] = ir2;
  assign sg_a[0] = s0;   assign sg_a[1] = s1;   assign sg_a[2] = s2;
  assign bcd_a[0] = {8'd0, bcd0};
  assign bcd_a[1] = {8'd0, bcd1};
  assign bcd_a[2] = bcd2;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Decimal digits of the magnitude, built with plain division.
  function automatic logic [19:0] ref_bcd(input int w, input logic [15:0] v, output logic neg);
    int mag;
    logic [19:0] r;
    mag = int'(v) & ((1 << bw[w]) - 1);
    neg = 1'b0;
    if (sgn[w] != 0 && mag >= (1 << (bw[w] - 1))) begin
      mag = (1 << bw[w]) - mag;
      neg = 1'b1;
    end
    r = 20'd0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return r;
  endfunction

  // Call at a negedge; returns at the negedge after the output handshake.
  task automatic convert(input int w, input logic [15:0] val, input int hold, output int acc);
    int n;
    logic [19:0] exp_bcd;
    logic exp_neg;
    exp_bcd = ref_bcd(w, val, exp_neg);
    n = 0;
    while (!ir_a[w] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_wait", 32'(ir_a[w]), 32'd1);
    acc = cyc;
    iv[w] = 1'b1;
    idata[w] = val;
    ordy[w] = (hold == 0);
    @(posedge clk);
    #1 iv[w] = 1'b0;
    n = 0;
    @(negedge clk);
    check_eq("busy_in_ready", 32'(ir_a[w]), 32'd0);
    while (!ov_a[w] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", 32'(n), 32'(bw[w]));
    check_eq("bcd_out", 32'(bcd_a[w]), 32'(exp_bcd));
    check_eq("sign_out", 32'(sg_a[w]), 32'(exp_neg));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      iv[w] = 1'($urandom_range(0, 1));
      idata[w] = 16'($urandom);
      check_eq("bp_out_valid", 32'(ov_a[w]), 32'd1);
      check_eq("bp_in_ready", 32'(ir_a[w]), 32'd0);
      check_eq("bp_bcd_hold", 32'(bcd_a[w]), 32'(exp_bcd));
    end
    iv[w] = 1'b0;
    ordy[w] = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", 32'(ir_a[w]), 32'd1);
    check_eq("idle_out_valid", 32'(ov_a[w]), 32'd0);
    check_eq("idle_bcd_hold", 32'(bcd_a[w]), 32'(exp_bcd));
  endtask

  initial begin
    int acc, prev;
    logic [15:0] v;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      idata[i] = 16'd0;
      ordy[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_in_ready", 32'(ir_a[i]), 32'd1);
      check_eq("rst_out_valid", 32'(ov_a[i]), 32'd0);
      check_eq("rst_bcd", 32'(bcd_a[i]), 32'd0);
      check_eq("rst_sign", 32'(sg_a[i]), 32'd0);
    end

    convert(0, 16'h00FF, 0, acc);
    check_eq("dir_255", 32'(bcd_a[0]), 32'h255);
    convert(0, 16'd0, 0, acc);
    convert(0, 16'd99, 0, acc);
    check_eq("dir_99", 32'(bcd_a[0]), 32'h099);

    // Exhaustive sweep with back-to-back spacing check
    prev = 0;
    for (int i = 0; i < 256; i++) begin
      convert(0, 16'(i), 0, acc);
      if (i > 0) check_eq("spacing", 32'(acc - prev), 32'd10);
      prev = acc;
    end

    convert(0, 16'($urandom_range(0, 255)), 20, acc);

    // Reset during the fourth shift cycle of a conversion of 0xFF
    iv[0] = 1'b1;
    idata[0] = 16'h00FF;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(ov_a[0]), 32'd0);
    check_eq("mid_rst_bcd", 32'(bcd_a[0]), 32'd0);
    check_eq("mid_rst_in_ready", 32'(ir_a[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_out_valid", 32'(ov_a[0]), 32'd0);
    convert(0, 16'd42, 0, acc);
    check_eq("dir_42", 32'(bcd_a[0]), 32'h042);

    convert(1, 16'h0080, 0, acc);
    check_eq("sgn_m128", 32'({sg_a[1], bcd_a[1]}), 32'h100128);
    convert(1, 16'h00FF, 0, acc);
    check_eq("sgn_m1", 32'({sg_a[1], bcd_a[1]}), 32'h100001);
    convert(1, 16'h007F, 0, acc);
    check_eq("sgn_p127", 32'({sg_a[1], bcd_a[1]}), 32'h000127);
    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom_range(0, 255));
      convert(1, v, int'($urandom_range(0, 3)), acc);
    end

    convert(2, 16'hFFFF, 0, acc);
    check_eq("w16_65535", 32'(bcd_a[2]), 32'h65535);
    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom_range(0, 65535));
      convert(2, v, int'($urandom_range(0, 3)), acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
